// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// div_unit -- multi-cycle RV32M DIV/DIVU/REM/REMU, restoring radix-2 divider
//             (one quotient bit per cycle plus one sign/select fix-up cycle).
// Revision: 1.0
// ============================================================================
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      Op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic            flush,
   output logic            Busy,
   output logic            Done,
   output logic [XLEN-1:0] Result
);

   localparam int CW = $clog2(XLEN) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

   logic [1:0]      state_q,    state_d;
   logic            is_rem_q,   is_rem_d;
   logic            neg_quo_q,  neg_quo_d;
   logic            neg_rem_q,  neg_rem_d;
   logic            div0_q,     div0_d;
   logic            ovf_q,      ovf_d;
   logic [XLEN-1:0] rem_q,      rem_d;
   logic [XLEN-1:0] quo_q,      quo_d;
   logic [XLEN-1:0] dvs_q,      dvs_d;
   logic [CW-1:0]   cnt_q,      cnt_d;
   logic [XLEN-1:0] result_q,   result_d;

   logic            w_accept;
   logic            w_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;
   logic            w_div0;
   logic            w_ovf;
   logic [XLEN:0]   w_rem_sh;
   logic [XLEN:0]   w_trial;
   logic [XLEN-1:0] w_quo_fix;
   logic [XLEN-1:0] w_rem_fix;

   assign w_accept  = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !flush;
   assign w_signed  = ~Op[0];
   assign w_a_neg   = w_signed & A[XLEN-1];
   assign w_b_neg   = w_signed & B[XLEN-1];
   assign w_a_mag   = w_a_neg ? (~A + 1'b1) : A;
   assign w_b_mag   = w_b_neg ? (~B + 1'b1) : B;
   assign w_div0    = (B == '0);
   assign w_ovf     = w_signed && (A == MIN_NEG) && (B == ALL_ONES);

   // Partial remainder is always below the divisor, so XLEN+1 bits hold the shifted value.
   assign w_rem_sh  = {rem_q, quo_q[XLEN-1]};
   assign w_trial   = w_rem_sh - {1'b0, dvs_q};
   assign w_quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
   assign w_rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

   always_comb begin
      state_d   = state_q;
      is_rem_d  = is_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      ovf_d     = ovf_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      result_d  = result_q;

      case (state_q)
         S_RUN: begin
            if (!w_trial[XLEN]) begin
               rem_d = w_trial[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d = w_rem_sh[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            // On divide-by-zero quo_q carries the raw dividend for REM/REMU.
            if (div0_q) begin
               result_d = is_rem_q ? quo_q : ALL_ONES;
            end else if (ovf_q) begin
               result_d = is_rem_q ? '0 : MIN_NEG;
            end else begin
               result_d = is_rem_q ? w_rem_fix : w_quo_fix;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = state_q;
         end
      endcase

      if (w_accept) begin
         is_rem_d  = Op[1];
         neg_quo_d = w_a_neg ^ w_b_neg;
         neg_rem_d = w_a_neg;
         div0_d    = w_div0;
         ovf_d     = w_ovf;
         rem_d     = '0;
         quo_d     = w_div0 ? A : w_a_mag;
         dvs_d     = w_b_mag;
         cnt_d     = CW'(XLEN);
         state_d   = (w_div0 || w_ovf) ? S_FIX : S_RUN;
      end

      if (flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         ovf_q     <= 1'b0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         is_rem_q  <= is_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         ovf_q     <= ovf_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
      end
   end

   assign Busy   = (state_q == S_RUN) || (state_q == S_FIX);
   assign Done   = (state_q == S_DONE);
   assign Result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// tb_div_unit -- directed vector table plus abort/back-to-back sequences.
// Revision: 1.0
// ============================================================================
module tb_div_unit;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;
   localparam int         LAT_N   = 33;
   localparam int         LAT_S   = 1;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        flush;
   logic        Busy;
   logic        Done;
   logic [31:0] Result;

   int tests;
   int fails;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vt[18];

   div_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .Op     (Op),
      .A      (A),
      .B      (B),
      .flush  (flush),
      .Busy   (Busy),
      .Done   (Done),
      .Result (Result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Drives one operation, scrambles operands after the sampling edge, and
   // returns the edge count to Done and the number of Busy cycles seen.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n, output int busy_cnt);
      @(negedge clk);
      Op = op; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; Op = ~op; A = 32'hDEADBEEF; B = 32'h0;
      n = 0;
      busy_cnt = 0;
      while (!Done && n < 100) begin
         if (Busy) busy_cnt++;
         @(posedge clk); #1;
         n++;
      end
   endtask

   initial begin
      int n;
      int bc;
      int done_seen;
      logic [31:0] prior;

      tests = 0;
      fails = 0;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; Op = 2'b00; A = '0; B = '0;

      vt[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         LAT_N};
      vt[1]  = '{OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   LAT_N};
      vt[2]  = '{OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   LAT_N};
      vt[3]  = '{OP_REMU, 32'hFFFFFFF9,   32'd2,          32'd1,          LAT_N};
      vt[4]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   LAT_S};
      vt[5]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          LAT_S};
      vt[6]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   LAT_S};
      vt[7]  = '{OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'h0,          LAT_S};
      vt[8]  = '{OP_DIVU, 32'd9,          32'd3,          32'd3,          LAT_N};
      vt[9]  = '{OP_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   LAT_N};
      vt[10] = '{OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          LAT_N};
      vt[11] = '{OP_DIV,  32'hFFFFFFF8,   32'hFFFFFFFD,   32'd2,          LAT_N};
      vt[12] = '{OP_REM,  32'hFFFFFFF8,   32'hFFFFFFFD,   32'hFFFFFFFE,   LAT_N};
      vt[13] = '{OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   LAT_N};
      vt[14] = '{OP_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   LAT_N};
      vt[15] = '{OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'h0,          LAT_N};
      vt[16] = '{OP_REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   LAT_S};
      vt[17] = '{OP_DIV,  32'h80000000,   32'd1,          32'h80000000,   LAT_N};

      repeat (2) @(posedge clk);
      #1;
      check("reset_busy",   {31'b0, Busy}, 32'd0);
      check("reset_done",   {31'b0, Done}, 32'd0);
      check("reset_result", Result,        32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         issue(vt[i].op, vt[i].a, vt[i].b, n, bc);
         check($sformatf("v%0d_latency", i), n, vt[i].lat);
         check($sformatf("v%0d_busy_cycles", i), bc, vt[i].lat);
         check($sformatf("v%0d_result", i), Result, vt[i].exp);
         check($sformatf("v%0d_busy_at_done", i), {31'b0, Busy}, 32'd0);
      end

      // Result must hold after Done falls
      issue(OP_DIVU, 32'd100, 32'd7, n, bc);
      check("hold_result_at_done", Result, 32'd14);
      repeat (10) @(posedge clk);
      #1;
      check("hold_done_low", {31'b0, Done}, 32'd0);
      check("hold_result_10", Result, 32'd14);

      // flush at RUN iteration 10
      prior = Result;
      @(negedge clk);
      Op = OP_DIVU; A = 32'd1000; B = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("flush_busy_before", {31'b0, Busy}, 32'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy", {31'b0, Busy}, 32'd0);
      check("flush_done", {31'b0, Done}, 32'd0);
      check("flush_result", Result, prior);
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (Done || Busy) done_seen++;
      end
      check("flush_no_done_later", done_seen, 0);
      check("flush_result_later", Result, prior);

      // flush wins over simultaneous start
      @(negedge clk);
      Op = OP_DIVU; A = 32'd50; B = 32'd5; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flush_vs_start_busy", {31'b0, Busy}, 32'd0);
      repeat (40) @(posedge clk);
      #1;
      check("flush_vs_start_result", Result, prior);

      // start while Busy ignored
      @(negedge clk);
      Op = OP_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      repeat (3) begin
         @(posedge clk); #1;
         n++;
      end
      start = 1'b1; Op = OP_DIVU; A = 32'd9; B = 32'd3;
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      while (!Done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("busy_start_latency", n, LAT_N);
      check("busy_start_result", Result, 32'd14);

      // back-to-back: start held in the Done cycle
      start = 1'b1; Op = OP_DIVU; A = 32'd9; B = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_busy", {31'b0, Busy}, 32'd1);
      check("b2b_done_low", {31'b0, Done}, 32'd0);
      n = 0;
      while (!Done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("b2b_latency", n, LAT_N);
      check("b2b_result", Result, 32'd3);

      // async reset mid-RUN
      @(negedge clk);
      Op = OP_DIVU; A = 32'd77; B = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_busy",   {31'b0, Busy}, 32'd0);
      check("rst_done",   {31'b0, Done}, 32'd0);
      check("rst_result", Result,        32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (Done) done_seen++;
      end
      check("rst_no_done_later", done_seen, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
